// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the parametrised register file
package regfile_pkg;
    localparam int   DEF_WIDTH    = 32;
    localparam int   DEF_NUM_REGS = 32;
    localparam int   ZERO_REG     = 0;
    localparam logic Z_BIT        = 1'bz;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port with write-first bypass, busy lookup and tri-state output
import regfile_pkg::*;

module regfile_read_port #(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] i_regs,
    input  logic [NUM_REGS-1:0]            i_busy,
    input  logic                           i_we,
    input  logic [ADDR_W-1:0]              i_wr_addr,
    input  logic [WIDTH-1:0]               i_wr_data,
    input  logic                           i_re,
    input  logic [ADDR_W-1:0]              i_rd_addr,
    output logic [WIDTH-1:0]               o_rd_data,
    output logic                           o_busy
);
    logic             w_hit;
    logic             w_byp;
    logic [WIDTH-1:0] w_data;

    assign w_hit     = i_we && (i_wr_addr == i_rd_addr);
    assign w_byp     = w_hit && (i_wr_addr != ADDR_W'(ZERO_REG));
    assign w_data    = w_byp ? i_wr_data : i_regs[i_rd_addr];
    assign o_rd_data = i_re ? w_data : {WIDTH{Z_BIT}};
    // a same-cycle write to the read address hides the busy bit, matching the bypass
    assign o_busy    = i_busy[i_rd_addr] & i_re & ~w_hit;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: NUM_REGS x WIDTH register file, r0 hardwired zero, two read ports, busy scoreboard
import regfile_pkg::*;

module regfile_param #(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              busy_a,
    output logic              busy_b
);
    logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0]            r_busy;

    // storage: clear overrides writes; writes to r0 are dropped so it stays zero
    always_ff @(posedge clk) begin
        if (clr)
            r_regs <= '0;
        else if (we && wr_addr != ADDR_W'(ZERO_REG))
            r_regs[wr_addr] <= wr_data;
    end

    // scoreboard: clear, then set (wins over a clearing write), then write clears
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr)
                r_busy[i] <= 1'b0;
            else if (busy_set && busy_addr == ADDR_W'(i) && i != ZERO_REG)
                r_busy[i] <= 1'b1;
            else if (we && wr_addr == ADDR_W'(i))
                r_busy[i] <= 1'b0;
        end
    end

    regfile_read_port #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_port_a (
        .i_regs(r_regs), .i_busy(r_busy), .i_we(we), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_re(re_a), .i_rd_addr(rd_addr_a), .o_rd_data(rd_data_a), .o_busy(busy_a)
    );

    regfile_read_port #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_port_b (
        .i_regs(r_regs), .i_busy(r_busy), .i_we(we), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_re(re_b), .i_rd_addr(rd_addr_b), .o_rd_data(rd_data_b), .o_busy(busy_b)
    );
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed self-checking bench for regfile_param
module tb_regfile_param;
    logic        clk = 1'b0;
    logic        clr, we, re_a, re_b, busy_set;
    logic [4:0]  wr_addr, rd_addr_a, rd_addr_b, busy_addr;
    logic [31:0] wr_data;
    wire  [31:0] rd_data_a, rd_data_b;
    wire         busy_a, busy_b;
    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] z32;

    regfile_param dut (
        .clk(clk), .clr(clr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .re_a(re_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .re_b(re_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_a(busy_a), .busy_b(busy_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        z32 = {32{1'bz}};
        clr = 1'b1; we = 1'b0; re_a = 1'b1; re_b = 1'b1; busy_set = 1'b0;
        wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; busy_addr = '0; wr_data = '0;
        tick();
        clr = 1'b0; rd_addr_a = 5'd5; #1;
        check("rst_r5", rd_data_a, 32'h0);
        check("rst_busy_a", {31'b0, busy_a}, 32'h0);
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
        tick();
        we = 1'b0; #1;
        check("wr_r5", rd_data_a, 32'hA5A5A5A5);
        busy_set = 1'b1; busy_addr = 5'd5;
        tick();
        busy_set = 1'b0; #1;
        check("busy_r5", {31'b0, busy_a}, 32'h1);
        clr = 1'b1; we = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; busy_set = 1'b1; busy_addr = 5'd6;
        tick();
        clr = 1'b0; we = 1'b0; busy_set = 1'b0; rd_addr_b = 5'd6; #1;
        check("clr_r5", rd_data_a, 32'h0);
        check("clr_busy_a", {31'b0, busy_a}, 32'h0);
        check("clr_busy_b6", {31'b0, busy_b}, 32'h0);
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h5A5A5A5A;
        tick();
        we = 1'b0; wr_data = 32'hFFA5A5A5; rd_addr_a = 5'd7; #1;
        check("wr_r7", rd_data_a, 32'h5A5A5A5A);
        tick();
        check("hold_r7", rd_data_a, 32'h5A5A5A5A);
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rd_addr_b = 5'd0; #1;
        check("zero_nobyp", rd_data_b, 32'h0);
        tick();
        we = 1'b0; #1;
        check("zero_r0", rd_data_b, 32'h0);
        busy_set = 1'b1; busy_addr = 5'd0;
        tick();
        busy_set = 1'b0; #1;
        check("busy_r0", {31'b0, busy_b}, 32'h0);
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h11111111;
        tick();
        wr_data = 32'h22222222; rd_addr_a = 5'd3; rd_addr_b = 5'd3; #1;
        check("byp_a", rd_data_a, 32'h22222222);
        check("byp_b", rd_data_b, 32'h22222222);
        tick();
        we = 1'b0; #1;
        check("wr_r3", rd_data_a, 32'h22222222);
        busy_set = 1'b1; busy_addr = 5'd9; rd_addr_a = 5'd9; rd_addr_b = 5'd9; #1;
        check("busy9_pre", {31'b0, busy_a}, 32'h0);
        tick();
        busy_set = 1'b0; #1;
        check("busy9_a", {31'b0, busy_a}, 32'h1);
        check("busy9_b", {31'b0, busy_b}, 32'h1);
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h0A0A0A0A;
        tick();
        #1;
        check("busy9_other_wr", {31'b0, busy_a}, 32'h1);
        wr_addr = 5'd9; wr_data = 32'h00000099; #1;
        check("busy9_hide", {31'b0, busy_a}, 32'h0);
        check("byp9", rd_data_a, 32'h00000099);
        tick();
        we = 1'b0; #1;
        check("busy9_clr", {31'b0, busy_a}, 32'h0);
        check("wr_r9", rd_data_a, 32'h00000099);
        busy_set = 1'b1; busy_addr = 5'd9; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h000000AA;
        tick();
        busy_set = 1'b0; we = 1'b0; #1;
        check("busy9_win", {31'b0, busy_a}, 32'h1);
        check("wr_r9_win", rd_data_a, 32'h000000AA);
        re_a = 1'b0; re_b = 1'b0; rd_addr_a = 5'd7; #1;
        check("tri_a", rd_data_a, z32);
        check("tri_b", rd_data_b, z32);
        check("tri_busy_a", {31'b0, busy_a}, 32'h0);
        check("tri_busy_b", {31'b0, busy_b}, 32'h0);
        re_a = 1'b1; #1;
        check("tri_restore", rd_data_a, 32'h5A5A5A5A);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
